shift_register_128to32: RTL and testbench
=========================================

Name: shift_register_128to32

Overview:
- Serializer: accepts one 128-bit AES block (ciphertext or plaintext) on a valid/ready input and emits it as four 32-bit words on a valid/ready output, MSB word first.
- It is the transmit-side counterpart of the 32-to-128 shift-in deserializer.
- Word order matches the deserializer: word 0 = bits [127:96], so chaining serializer into deserializer reproduces the block unchanged.
- Sits between the AES core output and the 32-bit bus/host interface.

Parameters:
- WORD_W, 32, output word width in bits.
- NUM_WORDS, 4, words per block; block width = WORD_W*NUM_WORDS (128).
- Only the defaults are verified. WORD_W*NUM_WORDS must equal 128.

Ports:
- clk  input  1  main clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- abort  input  1  synchronous clear; drops the block in flight.
- in_data  input  128  block to serialize.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepted on the cycle in_valid && in_ready.
- out_data  output  32  current word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts the word.
- out_last  output  1  out_data is the final word (word 3) of the block.
- busy  output  1  a block is held; equals out_valid.

Behaviour:
- Reset: reset_n low asynchronously clears shift_reg to 0, word count cnt to 0 and busy to 0.
  - Outputs in reset: out_valid=0, out_last=0, out_data=0, in_ready=1.
  - Reset mid-block discards the remaining words.
- State: IDLE (busy=0) and SEND (busy=1). cnt is ceil(log2(NUM_WORDS)) bits wide (2 bits at defaults).
- out_data = shift_reg[127:96]. out_valid = busy. out_last = busy && (cnt==NUM_WORDS-1).
- in_ready = !busy || (out_valid && out_ready && out_last). This combinational path allows back-to-back blocks.
- IDLE:
  - On in_valid && in_ready: shift_reg <= in_data, cnt <= 0, go to SEND.
  - First word appears on the next cycle (latency 1 cycle from accept).
- SEND:
  - On out_valid && out_ready and not last: shift_reg <= {shift_reg[95:0], 32'b0}, cnt <= cnt+1.
  - On last-word handshake with in_valid: load the new block, cnt <= 0, stay in SEND. There are no bubbles, so sustained throughput is 1 word/cycle (4 cycles/block).
  - On last-word handshake without in_valid: go to IDLE, cnt <= 0, shift_reg <= 0.
- Backpressure: while out_valid && !out_ready, out_data, out_last, cnt and shift_reg hold stable. Valid is never withdrawn.
- in_valid while busy and not on the last-word handshake: in_ready=0, nothing accepted, and the source must hold its block.
- abort (synchronous, highest priority after reset):
  - Same effect as reset: IDLE, shift_reg=0, cnt=0.
  - Overrides any simultaneous input or output handshake, which is then treated as not taken.
  - in_ready is forced to 0 during the abort cycle.
- The upstream source must not change in_data while in_valid && !in_ready.

Decomposition:
- aes_pkg holds:
  - constants AES_BLOCK_W=128, AES_WORD_W=32, AES_WORDS=4;
  - typedef aes_block_t (logic [127:0]);
  - typedef aes_word_t (logic [31:0]).
- No sub-module. This is a single flat block: one shift register, one counter and a two-state FSM.

Test Plan:
- Single block, out_ready held at 1: in_data=0x00112233_44556677_8899AABB_CCDDEEFF accepted at cycle t.
  - Required: out_data = 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF on cycles t+1..t+4.
  - Required: out_last only at t+4; busy falls at t+5.
- Back-to-back: two blocks presented continuously (second 0xDEADBEEF_01234567_89ABCDEF_FEEDFACE) with out_ready=1.
  - Required: 8 consecutive valid words with no gap.
  - Required: the second block is accepted on the cycle of the first block's out_last handshake.
- Backpressure: drop out_ready for 3 cycles during word 1.
  - Required: out_data stays at 0x44556677 with out_valid=1.
  - Required: in_ready=0 throughout; the remaining words follow in order after out_ready returns.
- Reset mid-block: assert reset_n=0 asynchronously after word 1 is delivered.
  - Required: out_valid=0, out_data=0 and in_ready=1 immediately, with no further words.
  - Required: the next block sent after reset release serializes starting from its word 0.
- Abort with a simultaneous handshake: abort=1 on the last-word handshake while in_valid=1.
  - Required: the new block is not accepted; next cycle busy=0 and in_ready=1.
- Loopback: serializer output feeds the 32-to-128 deserializer (shift_in = out_valid && out_ready) for random blocks.
  - Required: after 4 words the deserializer data_out equals the original in_data.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES datapath widths and block/word types for the serializer and deserializer.
package aes_pkg;
  localparam int AES_BLOCK_W = 128;
  localparam int AES_WORD_W  = 32;
  localparam int AES_WORDS   = 4;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;
  typedef logic [AES_WORD_W-1:0]  aes_word_t;
endpackage

// File: rtl/shift_register_128to32.sv
// 128-to-32 serializer: takes one AES block on a valid/ready input and emits
// four 32-bit words MSB first, reloading on the last handshake for zero bubbles.
module shift_register_128to32
  import aes_pkg::*;
#(
  parameter int WORD_W    = AES_WORD_W,
  parameter int NUM_WORDS = AES_WORDS
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        abort,
  input  logic [WORD_W*NUM_WORDS-1:0] in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [WORD_W-1:0]           out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic                        busy
);
  localparam int BLK_W = WORD_W * NUM_WORDS;
  localparam int CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

  logic [BLK_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             out_hs, last_hs, in_hs;

  assign out_data  = shift_q[BLK_W-1 -: WORD_W];
  assign out_valid = busy_q;
  assign busy      = busy_q;
  assign out_last  = busy_q && (cnt_q == LAST_CNT);

  assign out_hs  = out_valid && out_ready;
  assign last_hs = out_hs && out_last;
  // Combinational ready lets the next block load on the final word's handshake.
  assign in_ready = !abort && (!busy_q || last_hs);
  assign in_hs    = in_valid && in_ready;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (abort) begin
      shift_d = '0;
      cnt_d   = '0;
      busy_d  = 1'b0;
    end else if (in_hs) begin
      shift_d = in_data;
      cnt_d   = '0;
      busy_d  = 1'b1;
    end else if (last_hs) begin
      shift_d = '0;
      cnt_d   = '0;
      busy_d  = 1'b0;
    end else if (out_hs) begin
      shift_d = {shift_q[BLK_W-WORD_W-1:0], {WORD_W{1'b0}}};
      cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end
endmodule

// File: tb/tb_shift_register_128to32.sv
// Scoreboard bench for the 128-to-32 serializer: a word-queue model predicts
// every output word, in_ready, and the reassembled (loopback) block.
module tb_shift_register_128to32;
  import aes_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_word_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         abort = 1'b0;
  logic [127:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         out_last;
  logic         busy;

  int errors = 0;
  int checks = 0;

  exp_word_t    exp_q[$];
  logic [127:0] blk_q[$];
  logic [127:0] deser = '0;
  exp_word_t    w;
  logic [127:0] b;
  logic         exp_valid, exp_rdy;

  shift_register_128to32 dut (
    .clk(clk), .reset_n(reset_n), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor/model: compares at negedge, then advances the model past the coming posedge.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      blk_q.delete();
      deser = '0;
      chk("rst_out_valid", {127'b0, out_valid}, 128'd0);
      chk("rst_out_last", {127'b0, out_last}, 128'd0);
      chk("rst_out_data", {96'b0, out_data}, 128'd0);
      chk("rst_in_ready", {127'b0, in_ready}, 128'd1);
    end else begin
      exp_valid = (exp_q.size() != 0);
      chk("out_valid", {127'b0, out_valid}, {127'b0, exp_valid});
      chk("busy", {127'b0, busy}, {127'b0, exp_valid});
      if (exp_valid) begin
        chk("out_data", {96'b0, out_data}, {96'b0, exp_q[0].data});
        chk("out_last", {127'b0, out_last}, {127'b0, exp_q[0].last});
      end else begin
        chk("idle_data", {96'b0, out_data}, 128'd0);
        chk("idle_last", {127'b0, out_last}, 128'd0);
      end
      exp_rdy = !abort && (!exp_valid || (out_ready && exp_q.size() == 1));
      chk("in_ready", {127'b0, in_ready}, {127'b0, exp_rdy});
      if (abort) begin
        exp_q.delete();
        blk_q.delete();
        deser = '0;
      end else begin
        if (exp_valid && out_ready) begin
          w = exp_q.pop_front();
          deser = {deser[95:0], w.data};
          if (w.last) begin
            b = blk_q.pop_front();
            chk("loopback", deser, b);
          end
        end
        if (in_valid && exp_rdy) begin
          blk_q.push_back(in_data);
          for (int i = 0; i < 4; i++)
            exp_q.push_back('{data: in_data[127-32*i -: 32], last: (i == 3)});
        end
      end
    end
  end

  // Holds the block on the input until accepted; returns 1 ns after the accepting edge.
  task automatic send_block(input logic [127:0] blk);
    bit done = 0;
    int n = 0;
    in_data  = blk;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      done = in_ready && !abort;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 200) begin
        errors++;
        checks++;
        $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
        done = 1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d words pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    bit stop_rnd = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Single block, out_ready high
    send_block(128'h00112233_44556677_8899AABB_CCDDEEFF);
    drain();
    repeat (2) @(posedge clk); #1;

    // Back-to-back blocks with no gap
    send_block(128'h00112233_44556677_8899AABB_CCDDEEFF);
    send_block(128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE);
    drain();
    @(posedge clk); #1;

    // Backpressure on word 1
    send_block(128'h00112233_44556677_8899AABB_CCDDEEFF);
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    drain();
    @(posedge clk); #1;

    // Asynchronous reset after word 1 delivered
    send_block(128'h11111111_22222222_33333333_44444444);
    repeat (2) begin @(posedge clk); #1; end
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_valid", {127'b0, out_valid}, 128'd0);
    chk("async_rst_data", {96'b0, out_data}, 128'd0);
    chk("async_rst_in_ready", {127'b0, in_ready}, 128'd1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    send_block(128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3);
    drain();
    @(posedge clk); #1;

    // Abort on last-word handshake with a new block offered
    send_block(128'h01010101_02020202_03030303_04040404);
    repeat (3) begin @(posedge clk); #1; end
    in_data  = 128'hFFFF0000_EEEE1111_DDDD2222_CCCC3333;
    in_valid = 1'b1;
    abort    = 1'b1;
    @(posedge clk); #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("abort_busy", {127'b0, busy}, 128'd0);
    chk("abort_in_ready", {127'b0, in_ready}, 128'd1);
    @(posedge clk); #1;

    // Randomized blocks with random backpressure and gaps, checked via loopback
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          send_block({$urandom, $urandom, $urandom, $urandom});
        end
        stop_rnd = 1;
      end
      begin
        while (!stop_rnd) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish by 200000");
    $fatal(1, "timeout");
  end
endmodule
